// File: rtl/apb_bridge_ctrl_if.sv
// Bus bundle between the AHB slave pipeline, the APB sequencer and the APB peripherals.
// slave modport: the sequencer side. master modport: the environment driving it.
// Optional APB_PREADY_EN adds the Pready wire from the peripherals.
interface apb_bridge_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // AHB pipeline side
    logic              Valid;
    logic              Hwrite;
    logic              Hwrite_reg;
    logic [ADDR_W-1:0] Haddr;
    logic [ADDR_W-1:0] Haddr1;
    logic [ADDR_W-1:0] Haddr2;
    logic [DATA_W-1:0] Hwdata;
    logic [DATA_W-1:0] Hdata1;
    logic [2:0]        Tempselx;
    logic              Hreadyout;
    logic [DATA_W-1:0] Hrdata;

    // APB side
    logic [DATA_W-1:0] Prdata;
`ifdef APB_PREADY_EN
    logic              Pready;
`endif
    logic [2:0]        Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;

    modport slave (
        input  Valid, Hwrite, Hwrite_reg,
        input  Haddr, Haddr1, Haddr2,
        input  Hwdata, Hdata1, Tempselx,
        input  Prdata,
`ifdef APB_PREADY_EN
        input  Pready,
`endif
        output Pselx, Penable, Pwrite,
        output Paddr, Pwdata,
        output Hreadyout, Hrdata
    );

    modport master (
        output Valid, Hwrite, Hwrite_reg,
        output Haddr, Haddr1, Haddr2,
        output Hwdata, Hdata1, Tempselx,
        output Prdata,
`ifdef APB_PREADY_EN
        output Pready,
`endif
        input  Pselx, Penable, Pwrite,
        input  Paddr, Pwdata,
        input  Hreadyout, Hrdata
    );
endinterface

// File: rtl/apb_bridge_ctrl.sv
// APB-side sequencer of the AHB-to-APB bridge: runs APB SETUP/ENABLE
// transfers from the pipelined AHB slave outputs, stalls the master via
// Hreadyout and returns read data on Hrdata.
// Ports: Hclk, Hreset (sync, active-high), bus (apb_bridge_ctrl_if.slave).
// Optional: APB_PREADY_EN lets peripherals extend ENABLE with Pready=0.
module apb_bridge_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               Hclk,
    input  logic               Hreset,
    apb_bridge_ctrl_if.slave   bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WWAIT    = 3'd1;
    localparam logic [2:0] READ     = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
    localparam logic [2:0] WRITEP   = 3'd4;
    localparam logic [2:0] RENABLE  = 3'd5;
    localparam logic [2:0] WENABLE  = 3'd6;
    localparam logic [2:0] WENABLEP = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [2:0]        pselx_q, pselx_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              hready_q, hready_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;

    logic       go;
    logic       in_enable;
    logic       hold;
    logic [2:0] sel_safe;
    logic [2:0] from_idle;

`ifdef APB_PREADY_EN
    assign go = bus.Pready;
`else
    assign go = 1'b1;
`endif

    assign in_enable = (state_q == RENABLE) ||
                       (state_q == WENABLE) ||
                       (state_q == WENABLEP);

    // An ENABLE phase that the peripheral has not finished freezes everything.
    assign hold = in_enable && !go;

    // A broken decode must never select two peripherals at once.
    assign sel_safe = $onehot0(bus.Tempselx) ? bus.Tempselx : 3'b000;

    // Shared exit from IDLE and from a completed single ENABLE.
    always_comb begin
        from_idle = IDLE;
        if (bus.Valid && !bus.Hwrite) begin
            from_idle = READ;
        end else if (bus.Valid) begin
            from_idle = WWAIT;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                state_d = from_idle;
            end
            WWAIT: begin
                state_d = bus.Valid ? WRITEP : WRITE;
            end
            WRITE: begin
                state_d = bus.Valid ? WENABLEP : WENABLE;
            end
            WRITEP: begin
                state_d = WENABLEP;
            end
            READ: begin
                state_d = RENABLE;
            end
            WENABLEP: begin
                if (go) begin
                    if (!bus.Hwrite_reg) begin
                        state_d = READ;
                    end else if (bus.Valid) begin
                        state_d = WRITEP;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WENABLE, RENABLE: begin
                if (go) begin
                    state_d = from_idle;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output registers are loaded with the values of the state being entered.
    always_comb begin
        pselx_d   = pselx_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        hready_d  = hready_q;
        if (hold) begin
            hready_d = 1'b0;
        end else begin
            unique case (state_d)
                IDLE, WWAIT: begin
                    pselx_d   = 3'b000;
                    penable_d = 1'b0;
                    hready_d  = 1'b1;
                end
                READ: begin
                    pselx_d   = sel_safe;
                    paddr_d   = bus.Haddr;
                    pwrite_d  = 1'b0;
                    penable_d = 1'b0;
                    hready_d  = 1'b0;
                end
                WRITE, WRITEP: begin
                    pselx_d   = sel_safe;
                    pwrite_d  = 1'b1;
                    penable_d = 1'b0;
                    hready_d  = (state_d == WRITE);
                    // Chained writes sit one pipeline stage further back.
                    if (state_q == WENABLEP) begin
                        paddr_d  = bus.Haddr2;
                        pwdata_d = bus.Hdata1;
                    end else begin
                        paddr_d  = bus.Haddr1;
                        pwdata_d = bus.Hwdata;
                    end
                end
                RENABLE, WENABLE, WENABLEP: begin
                    penable_d = 1'b1;
                    hready_d  = 1'b1;
                end
                default: begin
                    pselx_d   = 3'b000;
                    penable_d = 1'b0;
                    hready_d  = 1'b1;
                end
            endcase
        end
    end

    // Read data is taken only when the ENABLE phase actually completes.
    always_comb begin
        hrdata_d = hrdata_q;
        if ((state_q == RENABLE) && go) begin
            hrdata_d = bus.Prdata;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q   <= IDLE;
            pselx_q   <= 3'b000;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hready_q  <= 1'b1;
            hrdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            pselx_q   <= pselx_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            hready_q  <= hready_d;
            hrdata_q  <= hrdata_d;
        end
    end

    assign bus.Pselx     = pselx_q;
    assign bus.Penable   = penable_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Hreadyout = hready_q;
    assign bus.Hrdata    = hrdata_q;

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Directed vector bench for apb_bridge_ctrl: per-cycle input/expected
// tables plus hand-written reset, decode and Pready sequences.
module tb_apb_bridge_ctrl;

    localparam logic [31:0] RA  = 32'h8000_0010;
    localparam logic [31:0] WA  = 32'h8400_0004;
    localparam logic [31:0] A   = 32'h8800_0000;
    localparam logic [31:0] B   = 32'h8800_0004;
    localparam logic [31:0] C   = 32'h8800_0008;
    localparam logic [31:0] E   = 32'h8400_0008;
    localparam logic [31:0] F   = 32'h8000_0020;
    localparam logic [31:0] Z   = 32'h9000_0000;
    localparam logic [31:0] G   = 32'h8000_0030;
    localparam logic [31:0] RD0 = 32'hA5A5_0001;
    localparam logic [31:0] WD  = 32'hDEAD_BEEF;
    localparam logic [31:0] D0  = 32'h1111_0000;
    localparam logic [31:0] D1  = 32'h2222_0000;
    localparam logic [31:0] D2  = 32'h3333_0000;
    localparam logic [31:0] D3  = 32'h4444_0000;
    localparam logic [31:0] R1  = 32'h5A5A_0002;
    localparam logic [31:0] R2  = 32'h0BAD_F00D;
    localparam logic [31:0] R3  = 32'hC0DE_0003;

    typedef struct {
        logic        rst;
        logic        valid;
        logic        hwrite;
        logic        hwreg;
        logic [31:0] haddr;
        logic [31:0] haddr1;
        logic [31:0] haddr2;
        logic [31:0] hwdata;
        logic [31:0] hdata1;
        logic [2:0]  tsel;
        logic [31:0] prdata;
        logic [2:0]  e_sel;
        logic        e_en;
        logic        e_wr;
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic        e_rdy;
        logic [31:0] e_hrdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vq[$];

    apb_bridge_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_bridge_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .Hclk   (clk),
        .Hreset (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(
        input logic r, input logic vl, input logic hw, input logic hr,
        input logic [31:0] ha, input logic [31:0] ha1,
        input logic [31:0] ha2, input logic [31:0] wd,
        input logic [31:0] wd1, input logic [2:0] ts,
        input logic [31:0] pr, input logic [2:0] es,
        input logic ee, input logic ew, input logic [31:0] ea,
        input logic [31:0] ed, input logic er, input logic [31:0] eh);
        vec_t x;
        x.rst = r;       x.valid = vl;     x.hwrite = hw;
        x.hwreg = hr;    x.haddr = ha;     x.haddr1 = ha1;
        x.haddr2 = ha2;  x.hwdata = wd;    x.hdata1 = wd1;
        x.tsel = ts;     x.prdata = pr;    x.e_sel = es;
        x.e_en = ee;     x.e_wr = ew;      x.e_paddr = ea;
        x.e_pwdata = ed; x.e_rdy = er;     x.e_hrdata = eh;
        return x;
    endfunction

    // Drive one cycle of inputs, let one posedge pass, sample 1 time unit later.
    task automatic drv(
        input logic r, input logic vl, input logic hw, input logic hr,
        input logic [31:0] ha, input logic [31:0] ha1,
        input logic [31:0] ha2, input logic [31:0] wd,
        input logic [31:0] wd1, input logic [2:0] ts,
        input logic [31:0] pr);
        @(negedge clk);
        rst            = r;
        bus.Valid      = vl;
        bus.Hwrite     = hw;
        bus.Hwrite_reg = hr;
        bus.Haddr      = ha;
        bus.Haddr1     = ha1;
        bus.Haddr2     = ha2;
        bus.Hwdata     = wd;
        bus.Hdata1     = wd1;
        bus.Tempselx   = ts;
        bus.Prdata     = pr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic idle_cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [101:0] got_b, exp_b;
        vec_t x;

        bus.Valid = 0;      bus.Hwrite = 0;   bus.Hwrite_reg = 0;
        bus.Haddr = 0;      bus.Haddr1 = 0;   bus.Haddr2 = 0;
        bus.Hwdata = 0;     bus.Hdata1 = 0;   bus.Tempselx = 0;
        bus.Prdata = 0;
`ifdef APB_PREADY_EN
        bus.Pready = 1'b1;
`endif

        // rst vl hw hr haddr haddr1 haddr2 hwdata hdata1 ts prdata | sel en wr paddr pwdata rdy hrdata
        vq.push_back(v(1,0,0,0, 0,0,0, 0,0, 0, 0,   0,0,0, 0,0,  1, 0));
        vq.push_back(v(1,0,0,0, 0,0,0, 0,0, 0, 0,   0,0,0, 0,0,  1, 0));
        // single read
        vq.push_back(v(0,1,0,0, RA,0,0, 0,0, 1, 0,  1,0,0, RA,0, 0, 0));
        vq.push_back(v(0,0,0,0, 0,0,0, 0,0, 0, RD0, 1,1,0, RA,0, 1, 0));
        vq.push_back(v(0,0,0,0, 0,0,0, 0,0, 0, RD0, 0,0,0, RA,0, 1, RD0));
        // single write
        vq.push_back(v(0,1,1,0, WA,0,0, 0,0, 2, 0,  0,0,0, RA,0, 1, RD0));
        vq.push_back(v(0,0,0,1, 0,WA,0, WD,0, 2, 0, 2,0,1, WA,WD,1, RD0));
        vq.push_back(v(0,0,0,0, 0,0,0, 0,0, 0, 0,   2,1,1, WA,WD,1, RD0));
        vq.push_back(v(0,0,0,0, 0,0,0, 0,0, 0, 0,   0,0,1, WA,WD,1, RD0));
        // burst of three writes
        vq.push_back(v(0,1,1,0, A,0,0, 0,0, 4, 0,   0,0,1, WA,WD,1, RD0));
        vq.push_back(v(0,1,1,1, B,A,0, D0,0, 4, 0,  4,0,1, A,D0, 0, RD0));
        vq.push_back(v(0,1,1,1, C,B,A, D1,D0, 4, 0, 4,1,1, A,D0, 1, RD0));
        vq.push_back(v(0,1,1,1, C,C,B, D2,D1, 4, 0, 4,0,1, B,D1, 0, RD0));
        vq.push_back(v(0,0,0,1, 0,C,B, 0,D1, 4, 0,  4,1,1, B,D1, 1, RD0));
        vq.push_back(v(0,0,0,1, 0,0,C, 0,D2, 4, 0,  4,0,1, C,D2, 1, RD0));
        vq.push_back(v(0,0,0,0, 0,0,0, 0,0, 4, 0,   4,1,1, C,D2, 1, RD0));
        vq.push_back(v(0,0,0,0, 0,0,0, 0,0, 0, 0,   0,0,1, C,D2, 1, RD0));
        // write then read through WENABLEP
        vq.push_back(v(0,1,1,0, E,0,0, 0,0, 2, 0,   0,0,1, C,D2, 1, RD0));
        vq.push_back(v(0,1,0,1, F,E,0, D3,0, 1, 0,  1,0,1, E,D3, 0, RD0));
        vq.push_back(v(0,1,0,0, F,F,E, 0,D3, 1, 0,  1,1,1, E,D3, 1, RD0));
        vq.push_back(v(0,0,0,0, F,0,E, 0,0, 1, 0,   1,0,0, F,D3, 0, RD0));
        vq.push_back(v(0,0,0,0, 0,0,0, 0,0, 0, R1,  1,1,0, F,D3, 1, RD0));
        vq.push_back(v(0,0,0,0, 0,0,0, 0,0, 0, R1,  0,0,0, F,D3, 1, R1));
        // read with no select, chained into a second read
        vq.push_back(v(0,1,0,0, Z,0,0, 0,0, 0, 0,   0,0,0, Z,D3, 0, R1));
        vq.push_back(v(0,1,0,0, G,0,0, 0,0, 1, R2,  0,1,0, Z,D3, 1, R1));
        vq.push_back(v(0,1,0,0, G,0,0, 0,0, 1, R2,  1,0,0, G,D3, 0, R2));
        vq.push_back(v(0,0,0,0, 0,0,0, 0,0, 0, R3,  1,1,0, G,D3, 1, R2));
        vq.push_back(v(0,0,0,0, 0,0,0, 0,0, 0, R3,  0,0,0, G,D3, 1, R3));

        foreach (vq[i]) begin
            x = vq[i];
            drv(x.rst, x.valid, x.hwrite, x.hwreg, x.haddr, x.haddr1,
                x.haddr2, x.hwdata, x.hdata1, x.tsel, x.prdata);
            got_b = {bus.Pselx, bus.Penable, bus.Pwrite, bus.Paddr,
                     bus.Pwdata, bus.Hreadyout, bus.Hrdata};
            exp_b = {x.e_sel, x.e_en, x.e_wr, x.e_paddr,
                     x.e_pwdata, x.e_rdy, x.e_hrdata};
            checks++;
            if (got_b !== exp_b) begin
                errors++;
                $display("FAIL vec%0d: got=%h expected=%h", i, got_b, exp_b);
            end
        end

        // Reset held two cycles in the middle of a write ENABLE.
        drv(0, 1, 1, 0, WA, 0, 0, 0, 0, 3'b010, 0);
        drv(0, 0, 0, 1, 0, WA, 0, WD, 0, 3'b010, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0);
        chk("wenable_pen", {31'd0, bus.Penable}, 1);
        for (int k = 0; k < 2; k++) begin
            drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0);
            chk("rst_psel", {29'd0, bus.Pselx}, 0);
            chk("rst_pen", {31'd0, bus.Penable}, 0);
            chk("rst_hready", {31'd0, bus.Hreadyout}, 1);
            chk("rst_paddr", bus.Paddr, 0);
            chk("rst_hrdata", bus.Hrdata, 0);
        end
        idle_cyc();
        chk("post_rst_psel", {29'd0, bus.Pselx}, 0);
        chk("post_rst_pen", {31'd0, bus.Penable}, 0);
        chk("post_rst_hready", {31'd0, bus.Hreadyout}, 1);

        // Multi-hot decode must not reach Pselx.
        drv(0, 1, 0, 0, RA, 0, 0, 0, 0, 3'b011, 0);
        chk("mh_psel", {29'd0, bus.Pselx}, 0);
        chk("mh_paddr", bus.Paddr, RA);
        chk("mh_hready", {31'd0, bus.Hreadyout}, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_7777);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_7777);
        chk("mh_hrdata", bus.Hrdata, 32'h0000_7777);

`ifdef APB_PREADY_EN
        // Peripheral stretches the read ENABLE by three cycles.
        drv(0, 1, 0, 0, RA, 0, 0, 0, 0, 3'b001, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pr_en0", {31'd0, bus.Penable}, 1);
        bus.Pready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFEED_0004);
            chk("pr_hold_en", {31'd0, bus.Penable}, 1);
            chk("pr_hold_rdy", {31'd0, bus.Hreadyout}, 0);
            chk("pr_hold_hrdata", bus.Hrdata, 32'h0000_7777);
        end
        bus.Pready = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFEED_0004);
        chk("pr_done_en", {31'd0, bus.Penable}, 0);
        chk("pr_done_hrdata", bus.Hrdata, 32'hFEED_0004);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
